// File: rtl/student_gpio_pkg.sv
// Shared definitions for the student PMOD GPIO APB slave.
// Register offsets are word indices taken from PADDR[4:2].
package student_gpio_pkg;

   localparam logic [2:0] DOUT_OFS    = 3'd0;
   localparam logic [2:0] OE_OFS      = 3'd1;
   localparam logic [2:0] DIN_OFS     = 3'd2;
   localparam logic [2:0] RISE_EN_OFS = 3'd3;
   localparam logic [2:0] FALL_EN_OFS = 3'd4;
   localparam logic [2:0] STATUS_OFS  = 3'd5;
   localparam logic [2:0] CTRL_OFS    = 3'd6;

   localparam int GIE_BIT    = 0;
   localparam int PAD_EN_BIT = 0;

   typedef enum logic [2:0] {
      SEL_DOUT,
      SEL_OE,
      SEL_DIN,
      SEL_RISE_EN,
      SEL_FALL_EN,
      SEL_STATUS,
      SEL_CTRL,
      SEL_RSVD
   } reg_sel_e;

   // Map a word offset onto the register it selects; anything unmapped is reserved.
   function automatic reg_sel_e decode_sel(input logic [2:0] ofs);
      case (ofs)
         DOUT_OFS:    return SEL_DOUT;
         OE_OFS:      return SEL_OE;
         DIN_OFS:     return SEL_DIN;
         RISE_EN_OFS: return SEL_RISE_EN;
         FALL_EN_OFS: return SEL_FALL_EN;
         STATUS_OFS:  return SEL_STATUS;
         CTRL_OFS:    return SEL_CTRL;
         default:     return SEL_RSVD;
      endcase
   endfunction

endpackage

// File: rtl/student_gpio_in_filter.sv
// Pad input path: synchronizer, optional debounce filter, edge detect.
// Build option: STUDENT_GPIO_DEBOUNCE_EN adds a tick-sampled stability filter.
module student_gpio_in_filter
   import student_gpio_pkg::*;
#(
   parameter int NPINS        = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_DIV = 1000
) (
   input  logic             clk_in,
   input  logic             reset_int,
   input  logic [NPINS-1:0] pin_in,
   input  logic [NPINS-1:0] rise_en,
   input  logic [NPINS-1:0] fall_en,
   output logic [NPINS-1:0] din,
   output logic [NPINS-1:0] rise,
   output logic [NPINS-1:0] fall
);

   logic [SYNC_STAGES-1:0][NPINS-1:0] sync_r;
   logic [NPINS-1:0]                  sync_q;
   logic [NPINS-1:0]                  din_d;

   assign sync_q = sync_r[SYNC_STAGES-1];

   // Metastability chain; stage 0 samples the raw asynchronous pads.
   always_ff @(posedge clk_in or posedge reset_int) begin
      if (reset_int) sync_r <= '0;
      else           sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
   end

`ifdef STUDENT_GPIO_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

   logic [CW-1:0]    pre_cnt;
   logic             tick;
   logic [NPINS-1:0] samp_q;
   logic [NPINS-1:0] filt_q;
   logic [NPINS-1:0] stable;

   assign tick   = (pre_cnt == CW'(DEBOUNCE_DIV - 1));
   assign stable = ~(sync_q ^ samp_q);

   // Shared prescaler, wraps every DEBOUNCE_DIV cycles.
   always_ff @(posedge clk_in or posedge reset_int) begin
      if (reset_int) pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   // A pin updates only when it matched the previous tick's sample.
   always_ff @(posedge clk_in or posedge reset_int) begin
      if (reset_int) begin
         samp_q <= '0;
         filt_q <= '0;
      end else if (tick) begin
         samp_q <= sync_q;
         filt_q <= (filt_q & ~stable) | (sync_q & stable);
      end
   end

   assign din = filt_q;
`else
   // Divider only matters for the filtered build.
   logic unused_div;
   assign unused_div = ^32'(DEBOUNCE_DIV);
   assign din = sync_q;
`endif

   // One-cycle delayed copy of din for edge detection.
   always_ff @(posedge clk_in or posedge reset_int) begin
      if (reset_int) din_d <= '0;
      else           din_d <= din;
   end

   assign rise = din & ~din_d & rise_en;
   assign fall = ~din & din_d & fall_en;

endmodule

// File: rtl/student_pmod_gpio_apb.sv
// APB GPIO slave for a student-slot PMOD pin group: registers, decode, irq.
// Build option: STUDENT_GPIO_DEBOUNCE_EN (input debounce in the filter).
module student_pmod_gpio_apb
   import student_gpio_pkg::*;
#(
   parameter int NPINS        = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_DIV = 1000
) (
   input  logic             clk_in,
   input  logic             reset_int,
   input  logic [31:0]      PADDR,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [31:0]      PWDATA,
   output logic [31:0]      PRDATA,
   output logic             PREADY,
   output logic             PSLVERR,
   input  logic             irq_en_3,
   input  logic [7:0]       ss_ctrl_3,
   input  logic [NPINS-1:0] pmod_gpi,
   output logic [NPINS-1:0] pmod_gpo,
   output logic [NPINS-1:0] pmod_gpio_oe,
   output logic             irq_3
);

   logic [NPINS-1:0] dout_q, oe_q, rise_en_q, fall_en_q, status_q;
   logic             gie_q, irq_q;
   logic [NPINS-1:0] din, rise, fall;
   logic [NPINS-1:0] wdata, w1c_mask, rd;
   logic             acc, err, wr, pad_en;
   reg_sel_e         sel;

   // Address/data bits outside the decoded window are don't-care.
   logic unused_ok;
   assign unused_ok = ^{PADDR[31:5], PADDR[1:0], PWDATA, ss_ctrl_3};

   // Reset abandons any in-flight access, so it also gates the APB outputs.
   assign acc    = PSEL & PENABLE & ~reset_int;
   assign sel    = decode_sel(PADDR[4:2]);
   assign err    = acc & ((sel == SEL_RSVD) | (PWRITE & (sel == SEL_DIN)));
   assign wr     = acc & PWRITE & ~err;
   assign wdata  = PWDATA[NPINS-1:0];
   assign pad_en = ss_ctrl_3[PAD_EN_BIT];

   assign w1c_mask = (wr && sel == SEL_STATUS) ? wdata : '0;

   student_gpio_in_filter #(
      .NPINS       (NPINS),
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_DIV(DEBOUNCE_DIV)
   ) u_in (
      .clk_in   (clk_in),
      .reset_int(reset_int),
      .pin_in   (pmod_gpi),
      .rise_en  (rise_en_q),
      .fall_en  (fall_en_q),
      .din      (din),
      .rise     (rise),
      .fall     (fall)
   );

   // Register file; new edges win over a same-cycle W1C.
   always_ff @(posedge clk_in or posedge reset_int) begin
      if (reset_int) begin
         dout_q    <= '0;
         oe_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         gie_q     <= 1'b0;
      end else begin
         if (wr && sel == SEL_DOUT)    dout_q    <= wdata;
         if (wr && sel == SEL_OE)      oe_q      <= wdata;
         if (wr && sel == SEL_RISE_EN) rise_en_q <= wdata;
         if (wr && sel == SEL_FALL_EN) fall_en_q <= wdata;
         if (wr && sel == SEL_CTRL)    gie_q     <= PWDATA[GIE_BIT];
         status_q <= (status_q & ~w1c_mask) | rise | fall;
      end
   end

   // Level interrupt, registered so it lags STATUS by one cycle.
   always_ff @(posedge clk_in or posedge reset_int) begin
      if (reset_int) irq_q <= 1'b0;
      else           irq_q <= (|status_q) & gie_q & irq_en_3 & pad_en;
   end

   // Read mux; reserved offset reads as zero.
   always_comb begin
      rd = '0;
      case (sel)
         SEL_DOUT:    rd = dout_q;
         SEL_OE:      rd = oe_q;
         SEL_DIN:     rd = din;
         SEL_RISE_EN: rd = rise_en_q;
         SEL_FALL_EN: rd = fall_en_q;
         SEL_STATUS:  rd = status_q;
         SEL_CTRL:    rd[GIE_BIT] = gie_q;
         default:     rd = '0;
      endcase
   end

   assign PRDATA       = acc ? 32'(rd) : 32'd0;
   assign PREADY       = acc;
   assign PSLVERR      = err;
   assign pmod_gpo     = dout_q;
   assign pmod_gpio_oe = oe_q & {NPINS{pad_en}};
   assign irq_3        = irq_q;

endmodule

// File: tb/tb_student_pmod_gpio_apb.sv
// Directed self-checking bench for student_pmod_gpio_apb.
// Build option: STUDENT_GPIO_DEBOUNCE_EN selects the debounce scenarios.
module tb_student_pmod_gpio_apb;

   localparam int NPINS = 16;

   logic             clk_in = 1'b0;
   logic             reset_int;
   logic [31:0]      PADDR, PWDATA, PRDATA;
   logic             PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic             irq_en_3;
   logic [7:0]       ss_ctrl_3;
   logic [NPINS-1:0] pmod_gpi, pmod_gpo, pmod_gpio_oe;
   logic             irq_3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   student_pmod_gpio_apb #(
      .NPINS(NPINS), .SYNC_STAGES(2), .DEBOUNCE_DIV(4)
   ) dut (
      .clk_in(clk_in), .reset_int(reset_int),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .irq_en_3(irq_en_3), .ss_ctrl_3(ss_ctrl_3), .pmod_gpi(pmod_gpi),
      .pmod_gpo(pmod_gpo), .pmod_gpio_oe(pmod_gpio_oe), .irq_3(irq_3)
   );

   // Single comparison point.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Two-phase APB write; returns at the negedge after the committing edge.
   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
      @(negedge clk_in);
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      @(negedge clk_in);
      PENABLE = 1'b1;
      #1;
      check("wr_pready", {31'd0, PREADY}, 32'd1);
      e = PSLVERR;
      @(negedge clk_in);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   // Two-phase APB read; data sampled mid access phase.
   task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
      @(negedge clk_in);
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      @(negedge clk_in);
      PENABLE = 1'b1;
      #1;
      check("rd_pready", {31'd0, PREADY}, 32'd1);
      d = PRDATA;
      e = PSLVERR;
      @(negedge clk_in);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e;
      logic [31:0] d;

      // Reset asserted with an access pending on the reserved offset.
      reset_int = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
      PADDR = 32'h1C; PWDATA = '0; irq_en_3 = 1'b0; ss_ctrl_3 = 8'h01;
      pmod_gpi = '0;
      repeat (3) @(negedge clk_in);
      check("rst_pready",  {31'd0, PREADY},  32'd0);
      check("rst_prdata",  PRDATA,           32'd0);
      check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
      check("rst_irq",     {31'd0, irq_3},   32'd0);
      check("rst_gpo",     32'(pmod_gpo),    32'd0);
      check("rst_oe",      32'(pmod_gpio_oe),32'd0);
      reset_int = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;

      apb_rd(32'h18, d, e);
      check("ctrl_rst", d, 32'd0);
      check("ctrl_rst_err", {31'd0, e}, 32'd0);

      // Outputs and pad gating.
      apb_wr(32'h00, 32'hA5A5, e);
      apb_wr(32'h04, 32'h00FF, e);
      check("gpo", 32'(pmod_gpo), 32'hA5A5);
      check("oe",  32'(pmod_gpio_oe), 32'h00FF);
      ss_ctrl_3 = 8'h00;
      @(negedge clk_in);
      check("oe_gated", 32'(pmod_gpio_oe), 32'h0000);
      apb_rd(32'h04, d, e);
      check("oe_readback", d, 32'h00FF);
      ss_ctrl_3 = 8'h01;

      // Upper bits of a register read back as zero.
      apb_wr(32'h00, 32'hFFFF_FFFF, e);
      apb_rd(32'h00, d, e);
      check("dout_width", d, 32'h0000_FFFF);

`ifndef STUDENT_GPIO_DEBOUNCE_EN
      // Pin 1 already high before its rise enable: level is not an edge.
      pmod_gpi[1] = 1'b1;
      repeat (5) @(negedge clk_in);
      apb_wr(32'h0C, 32'h0003, e);
      apb_wr(32'h18, 32'h0001, e);
      irq_en_3 = 1'b1;
      repeat (5) @(negedge clk_in);
      apb_rd(32'h14, d, e);
      check("no_level_event", d, 32'h0000);
      check("no_level_irq", {31'd0, irq_3}, 32'd0);

      // Rising edge: STATUS after 3 edges, irq one edge later.
      @(negedge clk_in);
      pmod_gpi[0] = 1'b1;
      @(negedge clk_in); check("rise_irq_c1", {31'd0, irq_3}, 32'd0);
      @(negedge clk_in); check("rise_irq_c2", {31'd0, irq_3}, 32'd0);
      @(negedge clk_in); check("rise_irq_c3", {31'd0, irq_3}, 32'd0);
      @(negedge clk_in); check("rise_irq_c4", {31'd0, irq_3}, 32'd1);
      apb_rd(32'h14, d, e);
      check("rise_status", d, 32'h0001);

      // W1C clears; irq follows one cycle later.
      apb_wr(32'h14, 32'h0001, e);
      check("w1c_irq_lag", {31'd0, irq_3}, 32'd1);
      @(negedge clk_in);
      check("w1c_irq_clr", {31'd0, irq_3}, 32'd0);
      apb_rd(32'h14, d, e);
      check("w1c_status", d, 32'h0000);

      // Falling edge on pin 15, then drop irq_en_3.
      apb_wr(32'h10, 32'h8000, e);
      pmod_gpi[15] = 1'b1;
      repeat (5) @(negedge clk_in);
      pmod_gpi[15] = 1'b0;
      repeat (5) @(negedge clk_in);
      check("fall_irq", {31'd0, irq_3}, 32'd1);
      irq_en_3 = 1'b0;
      @(negedge clk_in);
      check("irqen_drop", {31'd0, irq_3}, 32'd0);
      apb_rd(32'h14, d, e);
      check("irqen_status_kept", d, 32'h8000);
      irq_en_3 = 1'b1;
      repeat (2) @(negedge clk_in);
      check("irqen_restore", {31'd0, irq_3}, 32'd1);

      // W1C landing on the same edge as a new falling edge.
      pmod_gpi[15] = 1'b1;
      repeat (5) @(negedge clk_in);
      pmod_gpi[15] = 1'b0;
      apb_wr(32'h14, 32'h8000, e);
      repeat (2) @(negedge clk_in);
      check("collide_irq", {31'd0, irq_3}, 32'd1);
      apb_rd(32'h14, d, e);
      check("collide_status", d, 32'h8000);

      // Writing 0 is a no-op, writing 1 clears.
      apb_wr(32'h14, 32'h0000, e);
      apb_rd(32'h14, d, e);
      check("w1c_zero", d, 32'h8000);
      apb_wr(32'h14, 32'h8000, e);
      apb_rd(32'h14, d, e);
      check("w1c_bit15", d, 32'h0000);
`else
      // Short glitch on pin 3 is filtered out.
      apb_wr(32'h0C, 32'h0008, e);
      @(negedge clk_in);
      pmod_gpi[3] = 1'b1;
      repeat (3) @(negedge clk_in);
      pmod_gpi[3] = 1'b0;
      repeat (12) @(negedge clk_in);
      apb_rd(32'h08, d, e);
      check("db_glitch_din", d, 32'h0000);
      apb_rd(32'h14, d, e);
      check("db_glitch_status", d, 32'h0000);

      // A held level passes within two tick periods plus sync.
      pmod_gpi[3] = 1'b1;
      repeat (10) @(negedge clk_in);
      apb_rd(32'h08, d, e);
      check("db_hold_din", d, 32'h0008);
      apb_rd(32'h14, d, e);
      check("db_hold_status", d, 32'h0008);
      pmod_gpi = 16'h0003;
      repeat (14) @(negedge clk_in);
`endif

      // Error responses; pins currently 0x0003.
      apb_wr(32'h08, 32'hFFFF, e);
      check("din_wr_err", {31'd0, e}, 32'd1);
      apb_rd(32'h08, d, e);
      check("din_value", d, 32'h0003);
      check("din_rd_err", {31'd0, e}, 32'd0);
      apb_rd(32'h1C, d, e);
      check("rsvd_rd_err", {31'd0, e}, 32'd1);
      check("rsvd_rd_data", d, 32'h0000);
      apb_wr(32'h1C, 32'h1234, e);
      check("rsvd_wr_err", {31'd0, e}, 32'd1);
      apb_rd(32'h00, d, e);
      check("rsvd_wr_nostate", d, 32'h0000_FFFF);

      @(negedge clk_in);
      check("idle_prdata", PRDATA, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
